// File: rtl/hazard_ctrl_param.sv
// Hazard controller for the 5-stage 16-bit pipeline.
// Purpose: detects load-use hazards between IF/ID and ID/EX and drives stall/flush controls
// for the IF/ID and ID/EX registers. Also generates a multi-cycle flush after a taken branch
// and runs a halt-drain FSM that stops the pipeline once an HLT has reached writeback.
// Ports:
//   clk, rst         - pipeline clock, synchronous active-high reset
//   if_id_instr      - instruction held in IF/ID (consumer side)
//   id_ex_instr      - instruction held in ID/EX (producer side)
//   id_ex_MemToReg   - ID/EX instruction is a load
//   ex_branch_taken  - branch resolved taken in EX this cycle
//   stall            - hold PC and IF/ID, insert bubble into ID/EX
//   flush            - squash IF/ID contents
//   hlt_out          - halt has reached writeback
//   halted           - FSM is in the halted state
module hazard_ctrl_param #(
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned REG_W     = 4,
  parameter int unsigned LU_STALL  = 1,
  parameter int unsigned BR_FLUSH  = 1,
  parameter int unsigned HLT_DRAIN = 3,
  parameter bit          R0_ZERO   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] if_id_instr,
  input  logic [INSTR_W-1:0] id_ex_instr,
  input  logic               id_ex_MemToReg,
  input  logic               ex_branch_taken,
  output logic               stall,
  output logic               flush,
  output logic               hlt_out,
  output logic               halted
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e     state_q, state_d;
  logic [2:0] hc_q, hc_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic [1:0] fl_cnt_q, fl_cnt_d;

  logic [3:0]       opcode;
  logic             rs_hi;
  logic [REG_W-1:0] rs, rt, dest;
  logic             is_hlt;
  logic             lu_hit;
  logic             flush_raw;
  logic             run_stall;
  logic             unused_bits;

  assign opcode = if_id_instr[INSTR_W-1 -: 4];
  // SW, LHB and LLB carry their source register in the destination field.
  assign rs_hi  = (opcode == 4'b1001) || (opcode == 4'b1010) || (opcode == 4'b1011);
  assign rs     = rs_hi ? if_id_instr[8 +: REG_W] : if_id_instr[4 +: REG_W];
  assign rt     = if_id_instr[REG_W-1:0];
  assign dest   = id_ex_instr[8 +: REG_W];
  assign is_hlt = (opcode == 4'b1111);

  assign unused_bits = ^{id_ex_instr[INSTR_W-1:8+REG_W], id_ex_instr[7:0]};

  assign lu_hit = id_ex_MemToReg && ((rs == dest) || (rt == dest)) &&
                  !(R0_ZERO && (dest == '0));

  assign flush_raw = ex_branch_taken || (fl_cnt_q != 2'd0);
  // A flushed consumer is squashed, so its load-use stall is moot.
  assign run_stall = (lu_hit || (lu_cnt_q != 3'd0)) && !flush_raw;

  always_comb begin
    fl_cnt_d = fl_cnt_q;
    if (ex_branch_taken) begin
      fl_cnt_d = 2'(BR_FLUSH - 1);
    end else if (fl_cnt_q != 2'd0) begin
      fl_cnt_d = fl_cnt_q - 2'd1;
    end
  end

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    if (flush_raw) begin
      lu_cnt_d = 3'd0;
    end else if (lu_hit && (lu_cnt_q == 3'd0)) begin
      lu_cnt_d = 3'(LU_STALL - 1);
    end else if (lu_cnt_q != 3'd0) begin
      lu_cnt_d = lu_cnt_q - 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    unique case (state_q)
      StRun: begin
        // An HLT held by a stall or squashed by a flush must not start draining.
        if (is_hlt && !run_stall && !flush_raw) begin
          state_d = StDrain;
          hc_d    = 3'(HLT_DRAIN - 1);
        end
      end
      StDrain: begin
        if (ex_branch_taken) begin
          state_d = StRun;
          hc_d    = 3'd0;
        end else if (hc_q == 3'd0) begin
          state_d = StHalted;
        end else begin
          hc_d = hc_q - 3'd1;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StRun;
        hc_d    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      hc_q     <= 3'd0;
      lu_cnt_q <= 3'd0;
      fl_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  always_comb begin
    halted = (state_q == StHalted);
    stall  = halted || run_stall;
    flush  = !halted && flush_raw;
    // The last drain cycle is the one where HLT sits in writeback; a branch resolving in
    // that same cycle proves it speculative, so it must not report the halt.
    hlt_out = halted || ((state_q == StDrain) && (hc_q == 3'd0) && !ex_branch_taken);
  end

endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
Parametrised hazard controller for the 5-stage 16-bit pipeline. It replaces the fixed load-use and halt detector with four additions: a configurable load-use stall length, a taken-branch flush generator, a halt-drain state machine with configurable depth, and squash of a speculative HLT by a taken branch. It sits beside the IF/ID and ID/EX pipeline registers and drives their stall and flush controls.

Parameters:
INSTR_W, 16, instruction width; opcode is INSTR_W-1:INSTR_W-4.
REG_W, 4, register-specifier width.
LU_STALL, 1, stall cycles per load-use hazard; legal range 1..7.
BR_FLUSH, 1, flush cycles per taken branch; legal range 1..3.
HLT_DRAIN, 3, cycles from HLT in IF/ID to hlt_out; legal range 1..7.
R0_ZERO, 1, when 1 a destination of R0 never raises a hazard.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
if_id_instr  in  INSTR_W  instruction in IF/ID
id_ex_instr  in  INSTR_W  instruction in ID/EX
id_ex_MemToReg  in  1  ID/EX instruction is a load
ex_branch_taken  in  1  branch resolved taken in EX this cycle
stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
flush  out  1  squash IF/ID contents
hlt_out  out  1  halt reached writeback; pipeline stopped
halted  out  1  FSM is in HALTED (debug/status)

Behaviour:
- Reset: clk is the single clock; rst is synchronous and active-high. While rst=1 at a clk edge, all counters clear to 0 and the FSM goes to RUN. All outputs are 0 in the cycle after reset.
- Decode of if_id_instr:
  - rs = [11:8] for SW (1001), LHB (1010) and LLB (1011); otherwise [7:4].
  - rt = [3:0].
  - HLT = opcode 1111.
- Decode of id_ex_instr: dest = [11:8].
- lu_hit (combinational): id_ex_MemToReg & (rs==dest | rt==dest) & !(R0_ZERO & dest==0).
- Load-use counter lu_cnt (3 bits):
  - If lu_hit and lu_cnt==0, load LU_STALL-1.
  - Else if lu_cnt!=0, decrement.
  - Load-use stall term = lu_hit | (lu_cnt!=0).
  - With LU_STALL=1 this term is purely combinational.
- Flush counter fl_cnt (2 bits):
  - If ex_branch_taken, load BR_FLUSH-1. A branch taken while already flushing reloads the counter.
  - Else if fl_cnt!=0, decrement.
  - flush = ex_branch_taken | (fl_cnt!=0).
- Priority:
  - flush=1 suppresses the load-use stall term and clears lu_cnt on the same edge, because the consumer is being squashed.
  - HALTED overrides everything: stall=1 and flush=0.
- Halt FSM (states RUN, DRAIN, HALTED; 3-bit drain counter hc):
  - RUN: if HLT & !stall & !flush, go to DRAIN and set hc=HLT_DRAIN-1. An HLT held under stall does not advance the FSM.
  - DRAIN:
    - If ex_branch_taken, return to RUN; the HLT was speculative.
    - Else if hc==0, go to HALTED.
    - Else decrement hc.
    - DRAIN does not itself stall; older instructions continue.
  - HALTED: stall=1, hlt_out=1, halted=1. The only exit is rst.
- hlt_out rises exactly HLT_DRAIN cycles after the first un-stalled, un-flushed cycle with HLT in IF/ID. For the default of 3 this matches the previous controller.
- Simultaneous events:
  - lu_hit with HLT in IF/ID: the stall wins and the FSM waits.
  - ex_branch_taken with HLT in IF/ID in RUN: flush wins and the FSM stays in RUN.
- Reset mid-DRAIN or mid-HALTED returns to RUN with all outputs 0 on the next cycle.

Test Plan:
- Load-use, default parameters: id_ex = LW R3 (0x83xx), id_ex_MemToReg=1, if_id = ADD R1,R2,R3 (0x0123) -> stall=1 for 1 cycle. Repeat with dest R0 and R0_ZERO=1 -> stall=0.
- LU_STALL=3: a single load-use hit followed by a bubble in ID/EX -> stall high for exactly 3 consecutive cycles, then 0. Second case: SW R3 (0x93xx rs=[11:8]) behind LW R3 -> also stalls.
- BR_FLUSH=2: ex_branch_taken pulses 1 cycle while a load-use hit is present -> flush high for 2 cycles, stall=0 throughout, lu_cnt=0 afterwards.
- HLT: if_id=0xF000 with no hazards -> halted=0 for 3 cycles, hlt_out=1 on the 3rd edge and held. Stall stays 1 for 20 further cycles. Apply rst for 1 cycle -> all outputs 0.
- Speculative HLT: HLT enters DRAIN and ex_branch_taken=1 one cycle later -> FSM returns to RUN, hlt_out never rises, flush=1 for BR_FLUSH cycles.
- HLT arrives during a load-use stall (LU_STALL=2): FSM stays in RUN until stall drops, then hlt_out rises HLT_DRAIN cycles later (3 for the default).
